// File: rtl/uart_rx_frame.sv
// ---------------------------------------------------------------------------
// uart_rx_frame
//   Serial receive framer. Sits behind the high-to-low edge detector: the
//   detector's one-cycle start pulse launches a frame, the baud counter times
//   mid-bit samples from that pulse, the start bit is re-checked at its
//   midpoint, DATA_BITS data bits are shifted in LSB first and the stop bit is
//   validated. A good frame updates rx_data with a one-cycle rx_valid strobe;
//   a zero stop bit gives a one-cycle frame_err strobe instead.
//
// Ports
//   clk         in   rising-edge system clock
//   reset       in   asynchronous, active-low reset
//   rx_line     in   synchronised serial level, idle high
//   start_edge  in   one-cycle pulse on the 1->0 transition of rx_line
//   rx_data     out  last good byte, held until the next good frame
//   rx_valid    out  one-cycle strobe: rx_data updated this cycle
//   frame_err   out  one-cycle strobe: stop bit sampled low
//   busy        out  high whenever the framer is not idle
// ---------------------------------------------------------------------------
module uart_rx_frame #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD      = 9600,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_line,
  input  logic                 start_edge,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD;
  localparam int HALF     = BAUD_DIV / 2;
  localparam int CNT_W    = $clog2(BAUD_DIV);
  // One extra value so the index can count to DATA_BITS even when DATA_BITS = 1.
  localparam int IDX_W    = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BAUD_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shreg;

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      // Strobes live for exactly one cycle unless re-asserted below.
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;

      unique case (state)
        IDLE: begin
          if (start_edge) begin
            state <= START;
            cnt   <= '0;
          end
        end

        START: begin
          if (cnt == CNT_HALF) begin
            cnt <= '0;
            // A line back high at mid start bit was a glitch, not a frame.
            if (!rx_line) begin
              state   <= DATA;
              bit_idx <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DATA: begin
          if (cnt == CNT_FULL) begin
            cnt <= '0;
            // LSB arrives first, so each new bit enters at the MSB and the
            // earlier ones move down towards bit 0.
            for (int i = 0; i < DATA_BITS - 1; i++) begin
              shreg[i] <= shreg[i+1];
            end
            shreg[DATA_BITS-1] <= rx_line;
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == IDX_LAST) begin
              state <= STOP;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        STOP: begin
          if (cnt == CNT_FULL) begin
            cnt   <= '0;
            state <= IDLE;
            if (rx_line) begin
              rx_data  <= shreg;
              rx_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_frame
//   Directed bench for uart_rx_frame at 16 clocks per bit (HALF = 8).
//   The bench drives rx_line and start_edge on falling edges; E0 is the
//   rising edge that first sees start_edge high. A monitor samples outputs
//   1 time unit after every rising edge and logs strobes with their edge
//   number, so strobe timing is checked relative to E0.
// ---------------------------------------------------------------------------
module tb_uart_rx_frame;

  localparam int DATA_BITS = 8;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 rx_line;
  logic                 start_edge;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 frame_err;
  logic                 busy;

  uart_rx_frame #(
    .CLK_FREQ (16),
    .BAUD     (1),
    .DATA_BITS(DATA_BITS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_line   (rx_line),
    .start_edge(start_edge),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: edge counter and strobe log (only this process writes these).
  int                   cyc = 0;
  int                   valid_cnt = 0;
  int                   err_cnt = 0;
  int                   both_cnt = 0;
  int                   valid_cyc = -1;
  int                   err_cyc = -1;
  logic [DATA_BITS-1:0] valid_data = '0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (rx_valid) begin
      valid_cnt  = valid_cnt + 1;
      valid_cyc  = cyc;
      valid_data = rx_data;
    end
    if (frame_err) begin
      err_cnt = err_cnt + 1;
      err_cyc = cyc;
    end
    if (rx_valid && frame_err) both_cnt = both_cnt + 1;
  end

  int e0;
  int v_base;
  int e_base;

  // Sends one full 10-bit frame, 16 clocks per bit, starting on a falling edge.
  // inject: extra start_edge pulses during DATA and on the stop-sample edge.
  // rst_hit: pull reset low after edge E0+69 (asserted before E0+70), release 5 clk later.
  task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                            input bit inject, input bit rst_hit);
    logic [9:0] bits;
    bits = {stop_bit, data, 1'b0};
    v_base = valid_cnt;
    e_base = err_cnt;
    for (int j = 0; j < 10; j++) begin
      rx_line = bits[j];
      if (j == 0) start_edge = 1'b1;
      for (int k = 0; k < 16; k++) begin
        @(negedge clk);
        if (j == 0 && k == 0) begin
          e0 = cyc;
          start_edge = 1'b0;
          check("busy_after_e0", 32'(busy), 32'd1);
        end
        if (inject && ((j == 3 && k == 4) || (j == 6 && k == 11) || (j == 9 && k == 7)))
          start_edge = 1'b1;
        if (inject && ((j == 3 && k == 5) || (j == 6 && k == 12) || (j == 9 && k == 8)))
          start_edge = 1'b0;
        if (rst_hit && j == 4 && k == 5) begin
          reset = 1'b0;
          #1;
          check("rst_busy", 32'(busy), 32'd0);
          check("rst_data", 32'(rx_data), 32'd0);
          check("rst_valid", 32'(rx_valid), 32'd0);
          check("rst_err", 32'(frame_err), 32'd0);
        end
        if (rst_hit && j == 4 && k == 10) reset = 1'b1;
      end
    end
    // Stop sample was at E0+152; we are now just before E0+160.
    check("busy_end", 32'(busy), 32'd0);
  endtask

  task automatic idle(input int n);
    rx_line = 1'b1;
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    reset      = 1'b0;
    rx_line    = 1'b1;
    start_edge = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_data", 32'(rx_data), 32'd0);
    check("reset_valid", 32'(rx_valid), 32'd0);
    check("reset_err", 32'(frame_err), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    idle(4);

    // 1: good frame 0xA5
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
    check("t1_valid_cnt", 32'(valid_cnt - v_base), 32'd1);
    check("t1_valid_time", 32'(valid_cyc - e0), 32'd152);
    check("t1_valid_data", 32'(valid_data), 32'hA5);
    check("t1_err_cnt", 32'(err_cnt - e_base), 32'd0);
    check("t1_rx_data", 32'(rx_data), 32'hA5);
    idle(5);

    // 2: 3-clock glitch -> false start
    v_base = valid_cnt;
    e_base = err_cnt;
    rx_line    = 1'b0;
    start_edge = 1'b1;
    @(negedge clk);
    e0 = cyc;
    start_edge = 1'b0;
    check("t2_busy_e0", 32'(busy), 32'd1);
    repeat (2) @(negedge clk);
    rx_line = 1'b1;
    repeat (5) @(negedge clk);
    check("t2_busy_e7", 32'(busy), 32'd1);
    @(negedge clk);
    check("t2_busy_e8", 32'(busy), 32'd0);
    idle(10);
    check("t2_valid_cnt", 32'(valid_cnt - v_base), 32'd0);
    check("t2_err_cnt", 32'(err_cnt - e_base), 32'd0);
    check("t2_rx_data", 32'(rx_data), 32'hA5);

    // 3: 0x3C with stop bit 0 -> framing error
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    check("t3_err_cnt", 32'(err_cnt - e_base), 32'd1);
    check("t3_err_time", 32'(err_cyc - e0), 32'd152);
    check("t3_valid_cnt", 32'(valid_cnt - v_base), 32'd0);
    check("t3_rx_data", 32'(rx_data), 32'hA5);
    idle(5);

    // 4: back-to-back 0x00 then 0xFF
    send_frame(8'h00, 1'b1, 1'b0, 1'b0);
    check("t4a_valid_cnt", 32'(valid_cnt - v_base), 32'd1);
    check("t4a_valid_time", 32'(valid_cyc - e0), 32'd152);
    check("t4a_valid_data", 32'(valid_data), 32'h00);
    send_frame(8'hFF, 1'b1, 1'b0, 1'b0);
    check("t4b_valid_cnt", 32'(valid_cnt - v_base), 32'd1);
    check("t4b_valid_time", 32'(valid_cyc - e0), 32'd152);
    check("t4b_valid_data", 32'(valid_data), 32'hFF);
    idle(5);

    // 5: 0x81 with stray start_edge pulses mid-frame and at the stop sample
    send_frame(8'h81, 1'b1, 1'b1, 1'b0);
    check("t5_valid_cnt", 32'(valid_cnt - v_base), 32'd1);
    check("t5_valid_time", 32'(valid_cyc - e0), 32'd152);
    check("t5_valid_data", 32'(valid_data), 32'h81);
    check("t5_err_cnt", 32'(err_cnt - e_base), 32'd0);
    idle(20);
    check("t5_busy_idle", 32'(busy), 32'd0);

    // 6: async reset mid-frame, then a clean 0x5A
    send_frame(8'hC3, 1'b1, 1'b0, 1'b1);
    check("t6_abort_valid", 32'(valid_cnt - v_base), 32'd0);
    check("t6_abort_err", 32'(err_cnt - e_base), 32'd0);
    check("t6_abort_data", 32'(rx_data), 32'd0);
    idle(5);
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
    check("t6_valid_cnt", 32'(valid_cnt - v_base), 32'd1);
    check("t6_valid_time", 32'(valid_cyc - e0), 32'd152);
    check("t6_valid_data", 32'(valid_data), 32'h5A);
    idle(3);

    check("strobe_exclusive", 32'(both_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
